// File: rtl/spi_txn_sched_if.sv
// Purpose: bundles the FIFO-pop, SPI-master and read-response signals of the
//          SPI transaction scheduler into one interface.
// Modports:
//   master - scheduler side: drives fifo_rd_en, spi_start/wr/addr/wdata,
//            rsp_valid/rsp_data, busy, timeout_err.
//   slave  - environment side (FIFO, SPI master, response consumer): drives
//            sched_en, fifo_empty, fifo_rd_data, spi_done, spi_rdata, rsp_ready.
`timescale 1ns/1ps
interface spi_txn_sched_if #(
    parameter int DATA_WIDTH     = 41,
    parameter int SPI_ADDR_WIDTH = 8,
    parameter int SPI_DATA_WIDTH = 32
);
    logic                      sched_en;
    logic                      fifo_empty;
    logic                      fifo_rd_en;
    logic [DATA_WIDTH-1:0]     fifo_rd_data;
    logic                      spi_start;
    logic                      spi_wr;
    logic [SPI_ADDR_WIDTH-1:0] spi_addr;
    logic [SPI_DATA_WIDTH-1:0] spi_wdata;
    logic                      spi_done;
    logic [SPI_DATA_WIDTH-1:0] spi_rdata;
    logic                      rsp_valid;
    logic [SPI_DATA_WIDTH-1:0] rsp_data;
    logic                      rsp_ready;
    logic                      busy;
    logic                      timeout_err;

    modport master (
        input  sched_en, fifo_empty, fifo_rd_data, spi_done, spi_rdata, rsp_ready,
        output fifo_rd_en, spi_start, spi_wr, spi_addr, spi_wdata,
               rsp_valid, rsp_data, busy, timeout_err
    );

    modport slave (
        output sched_en, fifo_empty, fifo_rd_data, spi_done, spi_rdata, rsp_ready,
        input  fifo_rd_en, spi_start, spi_wr, spi_addr, spi_wdata,
               rsp_valid, rsp_data, busy, timeout_err
    );
endinterface

// File: rtl/spi_txn_sched.sv
// Purpose: read-side scheduler of the AHB->SPI async FIFO (SPI clock domain).
//          Pops one entry at a time, decodes it into an SPI transaction, runs
//          the start/done handshake with the SPI master, returns read data on
//          a valid/ready port and aborts stalled transactions after
//          TIMEOUT_CYCLES cycles in WAIT.
// Ports:
//   rd_clk  - clock (SPI / read domain)
//   rd_rst  - asynchronous active-high reset
//   bus     - spi_txn_sched_if.master (FIFO pop, SPI master, response, status)
//   txn_count / err_count (16 bit, only with SPI_TXN_SCHED_STATS_EN defined) -
//            saturating counts of accepted spi_done and of timeout aborts.
// Entry layout: [DATA_WIDTH-1] wr flag, then SPI_ADDR_WIDTH address bits,
//               low SPI_DATA_WIDTH bits write data.
`timescale 1ns/1ps
module spi_txn_sched #(
    parameter int DATA_WIDTH     = 41,
    parameter int SPI_ADDR_WIDTH = 8,
    parameter int SPI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TIMEOUT_W      = 16
) (
    input  logic            rd_clk,
    input  logic            rd_rst,
    spi_txn_sched_if.master bus
`ifdef SPI_TXN_SCHED_STATS_EN
    ,
    output logic [15:0]     txn_count,
    output logic [15:0]     err_count
`endif
);
    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, RESP} state_t;

    localparam logic [TIMEOUT_W-1:0] TIMER_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t                    state_q, state_d;
    logic [TIMEOUT_W-1:0]      timer_q, timer_d;
    logic                      spi_wr_q, spi_wr_d;
    logic [SPI_ADDR_WIDTH-1:0] spi_addr_q, spi_addr_d;
    logic [SPI_DATA_WIDTH-1:0] spi_wdata_q, spi_wdata_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [SPI_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic pop;
    logic start_pulse;
    logic timeout_pulse;
    logic done_accept;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            spi_wr_q    <= 1'b0;
            spi_addr_q  <= '0;
            spi_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            spi_wr_q    <= spi_wr_d;
            spi_addr_q  <= spi_addr_d;
            spi_wdata_q <= spi_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        spi_wr_d      = spi_wr_q;
        spi_addr_d    = spi_addr_q;
        spi_wdata_d   = spi_wdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        pop           = 1'b0;
        start_pulse   = 1'b0;
        timeout_pulse = 1'b0;
        done_accept   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.sched_en && !bus.fifo_empty) begin
                    pop     = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // FIFO data is valid the cycle after the pop strobe.
                spi_wr_d    = bus.fifo_rd_data[DATA_WIDTH-1];
                spi_addr_d  = bus.fifo_rd_data[DATA_WIDTH-2 -: SPI_ADDR_WIDTH];
                spi_wdata_d = bus.fifo_rd_data[SPI_DATA_WIDTH-1:0];
                state_d     = START;
            end
            START: begin
                start_pulse = 1'b1;
                timer_d     = '0;
                state_d     = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + TIMEOUT_W'(1);
                // A done arriving on the last allowed cycle beats the timeout.
                if (bus.spi_done) begin
                    done_accept = 1'b1;
                    if (spi_wr_q) begin
                        state_d = IDLE;
                    end else begin
                        rsp_data_d  = bus.spi_rdata;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    timeout_pulse = 1'b1;
                    state_d       = IDLE;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The pop decision is combinational from IDLE; masking with rd_rst keeps
    // the strobe low while reset is held even if the FIFO has data.
    assign bus.fifo_rd_en  = pop && !rd_rst;
    assign bus.spi_start   = start_pulse;
    assign bus.spi_wr      = spi_wr_q;
    assign bus.spi_addr    = spi_addr_q;
    assign bus.spi_wdata   = spi_wdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.timeout_err = timeout_pulse;

`ifdef SPI_TXN_SCHED_STATS_EN
    logic [15:0] txn_count_q, txn_count_d;
    logic [15:0] err_count_q, err_count_d;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            txn_count_q <= '0;
            err_count_q <= '0;
        end else begin
            txn_count_q <= txn_count_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        txn_count_d = txn_count_q;
        err_count_d = err_count_q;
        if (done_accept && (txn_count_q != 16'hFFFF)) begin
            txn_count_d = txn_count_q + 16'd1;
        end
        if (timeout_pulse && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    assign txn_count = txn_count_q;
    assign err_count = err_count_q;
`endif
endmodule

// File: tb/tb_spi_txn_sched.sv
`timescale 1ns/1ps
module tb_spi_txn_sched;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int EW = 41;
    localparam int TC = 8;
    localparam int TW = 16;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            delay;   // WAIT cycle index of spi_done, -1 = never
        logic [DW-1:0] rdata;
    } txn_t;

    logic rd_clk = 1'b0;
    logic rd_rst;
    always #5 rd_clk = ~rd_clk;

    spi_txn_sched_if #(.DATA_WIDTH(EW), .SPI_ADDR_WIDTH(AW), .SPI_DATA_WIDTH(DW)) bus ();

`ifdef SPI_TXN_SCHED_STATS_EN
    logic [15:0] txn_count;
    logic [15:0] err_count;
`endif

    spi_txn_sched #(
        .DATA_WIDTH(EW), .SPI_ADDR_WIDTH(AW), .SPI_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TC), .TIMEOUT_W(TW)
    ) dut (
        .rd_clk(rd_clk),
        .rd_rst(rd_rst),
        .bus(bus)
`ifdef SPI_TXN_SCHED_STATS_EN
        ,
        .txn_count(txn_count),
        .err_count(err_count)
`endif
    );

    txn_t          fifo_q[$];
    txn_t          exp_q[$];
    logic [DW-1:0] exp_rsp_q[$];
    txn_t          cur;

    int total = 0;
    int bad   = 0;
    int cyc = 0, pop_cyc = -100, last_start_cyc = -1;
    int n_pops = 0, n_starts = 0, n_to = 0;
    int done_cnt = -1, exp_to_cyc = -1, exp_gap = 0;
    int valid_cnt = 0, ready_delay = 0, hs_valid_cycles = 0;
    int exp_txn_cnt = 0, exp_err_cnt = 0;
    bit idle_next = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int dly, input logic [DW-1:0] rd);
        txn_t t;
        t.wr = wr; t.addr = a; t.wdata = d; t.delay = dly; t.rdata = rd;
        fifo_q.push_back(t);
        exp_q.push_back(t);
        bus.fifo_empty = 1'b0;
    endtask

    // One clock cycle: sample outputs at negedge+1, then model the FIFO,
    // SPI master and response consumer just after the rising edge.
    task automatic step();
        bit   do_pop;
        txn_t e;
        #1;
        do_pop = bus.fifo_rd_en;
        if (idle_next) begin
            check_eq("busy_after_end", bus.busy, 1'b0);
            idle_next = 1'b0;
        end
        if (bus.fifo_rd_en) begin
            check_eq("pop_nonempty", fifo_q.size() != 0, 1'b1);
            pop_cyc = cyc;
            n_pops++;
        end
        if (bus.spi_start) begin
            n_starts++;
            check_eq("start_latency", cyc - pop_cyc, 2);
            if (exp_gap != 0 && last_start_cyc >= 0)
                check_eq("start_gap", cyc - last_start_cyc, exp_gap);
            last_start_cyc = cyc;
            if (exp_q.size() == 0) begin
                check_eq("start_unexpected", 1'b1, 1'b0);
            end else begin
                cur = exp_q.pop_front();
                check_eq("spi_wr", bus.spi_wr, cur.wr);
                check_eq("spi_addr", bus.spi_addr, cur.addr);
                check_eq("spi_wdata", bus.spi_wdata, cur.wdata);
                done_cnt = cur.delay;
                if (cur.delay < 0) exp_to_cyc = cyc + TC;
                $display("txn %0d: wr=%0b addr=%02h wdata=%08h start at cycle %0d",
                         n_starts, bus.spi_wr, bus.spi_addr, bus.spi_wdata, cyc);
            end
        end
        if (bus.timeout_err || cyc == exp_to_cyc) begin
            check_eq("timeout_cycle", bus.timeout_err, cyc == exp_to_cyc);
            if (bus.timeout_err) begin
                idle_next = 1'b1;
                n_to++;
                exp_err_cnt++;
            end
            if (cyc == exp_to_cyc) exp_to_cyc = -1;
        end
        if (bus.rsp_valid) begin
            if (exp_rsp_q.size() == 0) begin
                check_eq("rsp_unexpected", 1'b1, 1'b0);
            end else begin
                check_eq("rsp_data", bus.rsp_data, exp_rsp_q[0]);
                if (bus.rsp_ready) begin
                    void'(exp_rsp_q.pop_front());
                    hs_valid_cycles = valid_cnt;
                    idle_next = 1'b1;
                    $display("rsp: data=%08h taken at cycle %0d", bus.rsp_data, cyc);
                end
            end
        end
        @(posedge rd_clk);
        #1;
        cyc++;
        if (do_pop && fifo_q.size() != 0) begin
            e = fifo_q.pop_front();
            bus.fifo_rd_data = {e.wr, e.addr, e.wdata};
            bus.fifo_empty = (fifo_q.size() == 0);
        end
        bus.spi_done = 1'b0;
        if (done_cnt == 0) begin
            bus.spi_done  = 1'b1;
            bus.spi_rdata = cur.rdata;
            exp_txn_cnt++;
            if (!cur.wr) exp_rsp_q.push_back(cur.rdata);
            done_cnt = -1;
        end else if (done_cnt > 0) begin
            done_cnt--;
        end
        if (bus.rsp_valid) begin
            bus.rsp_ready = (valid_cnt >= ready_delay);
            valid_cnt++;
        end else begin
            bus.rsp_ready = 1'b0;
            valid_cnt = 0;
        end
        @(negedge rd_clk);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || exp_rsp_q.size() != 0 ||
                bus.busy || done_cnt >= 0 || exp_to_cyc >= 0) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) check_eq({tag, "_drain_budget"}, 1'b1, 1'b0);
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_fifo_rd_en"}, bus.fifo_rd_en, 1'b0);
        check_eq({tag, "_spi_start"}, bus.spi_start, 1'b0);
        check_eq({tag, "_spi_wr"}, bus.spi_wr, 1'b0);
        check_eq({tag, "_spi_addr"}, bus.spi_addr, 0);
        check_eq({tag, "_spi_wdata"}, bus.spi_wdata, 0);
        check_eq({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
        check_eq({tag, "_rsp_data"}, bus.rsp_data, 0);
        check_eq({tag, "_busy"}, bus.busy, 1'b0);
        check_eq({tag, "_timeout_err"}, bus.timeout_err, 1'b0);
`ifdef SPI_TXN_SCHED_STATS_EN
        check_eq({tag, "_txn_count"}, txn_count, 0);
        check_eq({tag, "_err_count"}, err_count, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_p, base_s, base_to, n;
        rd_rst = 1'b1;
        bus.sched_en = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_rd_data = '0;
        bus.spi_done = 1'b0;
        bus.spi_rdata = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge rd_clk);
        #1;
        check_all_zero("reset");
        @(negedge rd_clk);
        rd_rst = 1'b0;
        bus.sched_en = 1'b1;

        // Single write, done on the third cycle after start.
        push_txn(1'b1, 8'h12, 32'hDEADBEEF, 2, 32'h0);
        wait_drain("write");
        check_eq("addr_hold", bus.spi_addr, 8'h12);

        // Single read, consumer holds ready low for 5 valid cycles.
        ready_delay = 5;
        push_txn(1'b0, 8'h34, 32'h0BAD0BAD, 1, 32'hCAFEF00D);
        wait_drain("read");
        check_eq("rsp_hold_cycles", hs_valid_cycles, 6);
        ready_delay = 0;

        // No done at all: abort after TC cycles in WAIT.
        base_to = n_to;
        push_txn(1'b1, 8'h56, 32'h11112222, -1, 32'h0);
        wait_drain("timeout");
        check_eq("timeout_count", n_to - base_to, 1);
`ifdef SPI_TXN_SCHED_STATS_EN
        check_eq("stats_err_after_to", err_count, 1);
        check_eq("stats_txn_after_to", txn_count, 2);
`endif

        // Three queued writes with immediate done run at the minimum period.
        base_p = n_pops; base_s = n_starts;
        exp_gap = 4; last_start_cyc = -1;
        for (int i = 0; i < 3; i++)
            push_txn(1'b1, 8'h60 + 8'(i), 32'hA0000000 + i, 0, 32'h0);
        wait_drain("b2b");
        exp_gap = 0;
        check_eq("b2b_pops", n_pops - base_p, 3);
        check_eq("b2b_starts", n_starts - base_s, 3);

        // sched_en dropped right after the first pop: only one transaction.
        bus.sched_en = 1'b0;
        for (int i = 0; i < 3; i++)
            push_txn(1'b1, 8'h70 + 8'(i), 32'hB0000000 + i, 0, 32'h0);
        base_p = n_pops; base_s = n_starts;
        bus.sched_en = 1'b1;
        n = 0;
        while (n_pops == base_p && n < 50) begin step(); n++; end
        bus.sched_en = 1'b0;
        repeat (20) step();
        check_eq("en0_pops", n_pops - base_p, 1);
        check_eq("en0_starts", n_starts - base_s, 1);
        check_eq("en0_busy", bus.busy, 1'b0);
        bus.sched_en = 1'b1;
        wait_drain("en0");

        // Done on the very last WAIT cycle wins over the timeout.
        base_to = n_to;
        push_txn(1'b1, 8'h80, 32'hC0C0C0C0, TC - 1, 32'h0);
        wait_drain("collide");
        check_eq("collide_no_timeout", n_to - base_to, 0);

        // Reset while a read is stalled in WAIT, with another entry queued.
        push_txn(1'b0, 8'h90, 32'h0, -1, 32'h0);
        push_txn(1'b1, 8'h91, 32'h91919191, 1, 32'h0);
        base_s = n_starts;
        n = 0;
        while (n_starts == base_s && n < 50) begin step(); n++; end
        repeat (3) step();
        check_eq("pre_rst_busy", bus.busy, 1'b1);
        rd_rst = 1'b1;
        #1;
        check_all_zero("rst_wait");
        done_cnt = -1;
        exp_to_cyc = -1;
        exp_txn_cnt = 0;
        exp_err_cnt = 0;
        base_p = n_pops;
        repeat (2) step();
        bus.sched_en = 1'b0;
        rd_rst = 1'b0;
        step();
        bus.spi_done = 1'b1;
        bus.spi_rdata = 32'h5A5A5A5A;
        repeat (4) step();
        check_eq("late_done_busy", bus.busy, 1'b0);
        check_eq("late_done_rsp", bus.rsp_valid, 1'b0);
        check_eq("rst_no_pop", n_pops - base_p, 0);
        bus.sched_en = 1'b1;
        wait_drain("after_rst");
        check_eq("after_rst_pop", n_pops - base_p, 1);

        check_eq("exp_queue_empty", exp_q.size(), 0);
`ifdef SPI_TXN_SCHED_STATS_EN
        check_eq("stats_txn_final", txn_count, exp_txn_cnt);
        check_eq("stats_err_final", err_count, exp_err_cnt);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
